// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Opcode/funct constants and fetch state encoding for the fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        RESOLVE = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module : fetch_unit_if
// Brief  : Instruction-memory read channel (req/ready handshake).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit_npc_calc.sv
// ============================================================================
// Module : npc_calc
// Brief  : Next-PC selection: jr > j/jal > taken branch > sequential.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module npc_calc
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [31:0]     ir,
    input  logic            jump,
    input  logic            branch,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] npc,
    output logic            misalign
);

    logic            is_jr;
    logic [PC_W-1:0] br_off;

    assign is_jr  = jump && (ir[31:26] == OP_RTYPE);
    // Word offset, sign-extended and scaled to bytes.
    assign br_off = {{(PC_W-18){ir[15]}}, ir[15:0], 2'b00};

    always_comb begin
        npc      = pc_plus4;
        misalign = 1'b0;
        if (is_jr) begin
            npc      = {jr_target[PC_W-1:2], 2'b00};
            misalign = |jr_target[1:0];
        end else if (jump) begin
            npc = {pc_plus4[PC_W-1:28], ir[25:0], 2'b00};
        end else if (branch) begin
            npc = pc_plus4 + br_off;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : PC sequencing and instruction fetch feeding the main controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    input  logic            stall,
    input  logic            Jump,
    input  logic            Branch,
    input  logic [PC_W-1:0] jr_target,
    output logic [31:0]     instr,
    output logic [5:0]      op,
    output logic [5:0]      func,
    output logic [PC_W-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            misalign
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [31:0]     ir_q, ir_d;
    logic            req_q, req_d;
    logic            instr_valid_q, instr_valid_d;
    logic            misalign_q, misalign_d;
    logic [PC_W-1:0] npc;
    logic            npc_misalign;

    npc_calc #(.PC_W(PC_W)) u_npc_calc (
        .pc_plus4  (pc_plus4_q),
        .ir        (ir_q),
        .jump      (Jump),
        .branch    (Branch),
        .jr_target (jr_target),
        .npc       (npc),
        .misalign  (npc_misalign)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        ir_d          = ir_q;
        instr_valid_d = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            FETCH: begin
                // Request is registered, so the first cycle after reset
                // release never accepts a stray ready.
                if (req_q && imem.imem_ready) begin
                    ir_d          = imem.imem_rdata;
                    pc_plus4_d    = pc_q + PC_W'(4);
                    instr_valid_d = 1'b1;
                    state_d       = DECODE;
                end
            end
            DECODE: state_d = RESOLVE;
            RESOLVE: begin
                if (!stall) begin
                    pc_d       = npc;
                    misalign_d = npc_misalign;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + PC_W'(4);
            ir_q          <= '0;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            ir_q          <= ir_d;
            req_q         <= req_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = ir_q;
    assign op             = ir_q[31:26];
    assign func           = ir_q[5:0];
    assign pc_plus4       = pc_plus4_q;
    assign instr_valid    = instr_valid_q;
    assign misalign       = misalign_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC sequencing stage directly upstream of the registered main controller.
- Holds the program counter and drives instruction memory with a req/ready handshake.
- Latches the returned instruction and presents op/func to the controller.
- One cycle later samples the controller's registered Jump/Branch to choose the next PC: sequential, branch, j/jal or jr.

Parameters:
- PC_W, 32, PC and instruction-memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction read request.
- imem_addr  out  PC_W  read address; equals pc while imem_req=1.
- imem_rdata  in  32  returned instruction word.
- imem_ready  in  1  rdata valid; honoured only when imem_req=1 in the same cycle.
- stall  in  1  holds the PC update while high (downstream hazard).
- Jump  in  1  registered controller output: j, jal or jr.
- Branch  in  1  registered controller output: taken beq/bne (zero already folded in).
- jr_target  in  PC_W  register-file rs value, used for jr.
- instr  out  32  instruction register (IR).
- op  out  6  IR[31:26], to controller.
- func  out  6  IR[5:0], to controller.
- pc_plus4  out  PC_W  pc+4 of the instruction in IR; link value for jal.
- instr_valid  out  1  one-cycle pulse when IR is loaded.
- misalign  out  1  one-cycle pulse when a jr target has bits[1:0] != 0.

Behaviour:
- Reset (async assert, sync release), any state:
  - pc=RESET_PC, IR=0, so op=func=0.
  - pc_plus4=RESET_PC+4; imem_req=0; instr_valid=0; misalign=0.
  - state=FETCH.
  - An outstanding fetch is abandoned; a late imem_ready is ignored because imem_req=0.
- States: FETCH -> DECODE -> RESOLVE -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stays in FETCH while imem_ready=0; imem_req and imem_addr are held stable.
  - On imem_ready=1: IR<=imem_rdata, pc_plus4<=pc+4, instr_valid pulses next cycle, go to DECODE.
  - Minimum fetch latency is 1 cycle (ready in the first req cycle).
- DECODE:
  - imem_req=0; op/func stable.
  - The controller registers Jump/Branch on this cycle's edge.
  - Unconditional transition to RESOLVE.
- RESOLVE:
  - If stall=1: hold. pc is unchanged and Jump/Branch are re-sampled every cycle.
  - If stall=0: pc<=npc, go to FETCH.
- npc priority, highest first:
  1. Jump && op==6'b000000 (jr): {jr_target[PC_W-1:2],2'b00}. misalign pulses if jr_target[1:0]!=0.
  2. Jump (j/jal): {pc_plus4[PC_W-1:28], IR[25:0], 2'b00}.
  3. Branch: pc_plus4 + ({{14{IR[15]}},IR[15:0]} << 2).
  4. Otherwise: pc_plus4.
- Jump and Branch both high: Jump wins.
- All additions are modulo 2^PC_W; wrap-around is silent (pc=32'hFFFF_FFFC -> pc_plus4=0).
- Negative branch offsets must sign-extend correctly; offset -1 branches to pc.
- Throughput: one instruction per 3 cycles with zero-wait memory and no stall.
- imem_ready asserted in DECODE or RESOLVE has no effect.

Decomposition:
- Shared package (cpu_pkg): opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_JAL=6'b000011; funct constant FN_JR=6'b001000; fetch state encoding FETCH/DECODE/RESOLVE.
- One combinational sub-module, npc_calc:
  - Inputs: pc_plus4, IR, Jump, Branch, jr_target.
  - Outputs: npc, misalign.
  - Kept separate so it can be unit-tested exhaustively on the priority rules.

Test Plan:
- Reset then zero-wait memory returning 32'h2010_0005 (addi) at each address, Jump=Branch=0 -> imem_addr sequence 0,4,8; instr_valid every 3rd cycle; op=6'b001000.
- IR=32'h1000_FFFF (beq, offset -1) at pc=0x40, Branch=1 in RESOLVE -> next imem_addr=0x40. Repeat with offset 0x0003 -> 0x50.
- IR=32'h0C00_0010 (jal) at pc=0x1000_0000, Jump=1 -> next addr=0x1000_0040; pc_plus4=0x1000_0004 held while in RESOLVE.
- IR=32'h03E0_0008 (jr), jr_target=0x123, Jump=1 -> next addr=0x120; misalign pulses one cycle. Same with Jump=Branch=1 -> jump still wins.
- imem_ready withheld 4 cycles -> imem_req/addr held constant; then stall=1 for 3 cycles in RESOLVE -> pc unchanged, no new req until stall drops.
- rst_n asserted mid-FETCH with ready pending, later ready pulse -> IR stays 0; fetch restarts at RESET_PC after release. pc=0xFFFF_FFFC -> next fetch at 0x0.
